mem_bus_arbiter: RTL

Arbitrates one shared single-port memory bus between the instruction-fetch port and the load/store (mem-stage) data port of the five-stage core. Sequences each access through a small request/response FSM, registers the memory response back to the winning requester, guards against a dead memory with a timeout, and prevents fetch starvation under back-to-back loads and stores. Per-port stall flags go to pipeline control.

---
 rtl/mem_bus_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one single-port memory bus between the instruction-fetch port (if_*)
// and the load/store data port (d_*). Each access goes IDLE -> BUSY -> RESP:
//   IDLE : pick a winner, latch its attributes into the m_* registers.
//   BUSY : hold m_req until m_ack, or give up after TIMEOUT cycles (err=1).
//   RESP : one-cycle ack to the owner with the registered rdata/err.
// Data normally wins a tie. After STARVE_MAX consecutive data grants while
// fetch was waiting, fetch wins the next tie.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   if_req/if_addr           fetch request, held until if_ack
//   if_ack/if_rdata/if_err   fetch completion pulse, read data, timeout flag
//   d_req/d_we/d_addr/
//   d_wdata/d_be             data request (store when d_we=1), held until d_ack
//   d_ack/d_rdata/d_err      data completion pulse, read data, timeout flag
//   m_req/m_we/m_addr/
//   m_wdata/m_be             memory request and its registered attributes
//   m_ack/m_rdata            memory completion and read data (same cycle)
//   if_stall/d_stall         request pending and not yet acknowledged
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic                  if_ack,
   output logic [DATA_W-1:0]     if_rdata,
   output logic                  if_err,

   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   input  logic [DATA_W/8-1:0]   d_be,
   output logic                  d_ack,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  d_err,

   output logic                  m_req,
   output logic                  m_we,
   output logic [ADDR_W-1:0]     m_addr,
   output logic [DATA_W-1:0]     m_wdata,
   output logic [DATA_W/8-1:0]   m_be,
   input  logic                  m_ack,
   input  logic [DATA_W-1:0]     m_rdata,

   output logic                  if_stall,
   output logic                  d_stall
);

   localparam int BE_W = DATA_W / 8;
   localparam int SC_W = $clog2(STARVE_MAX + 1);
   localparam int TC_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   state_e              state_q,     state_d;
   owner_e              owner_q,     owner_d;
   logic                m_we_q,      m_we_d;
   logic [ADDR_W-1:0]   m_addr_q,    m_addr_d;
   logic [DATA_W-1:0]   m_wdata_q,   m_wdata_d;
   logic [BE_W-1:0]     m_be_q,      m_be_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q,   rsp_err_d;
   logic [SC_W-1:0]     starve_q,    starve_d;
   logic [TC_W-1:0]     tmo_q,       tmo_d;

   logic                fetch_wins;
   logic                starved;

   assign starved = (starve_q == SC_W'(STARVE_MAX));

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which is what keeps this block free of latches.
      state_d     = state_q;
      owner_d     = owner_q;
      m_we_d      = m_we_q;
      m_addr_d    = m_addr_q;
      m_wdata_d   = m_wdata_q;
      m_be_d      = m_be_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      starve_d    = starve_q;
      tmo_d       = tmo_q;
      fetch_wins  = 1'b0;

      m_req       = 1'b0;
      if_ack      = 1'b0;
      d_ack       = 1'b0;
      if_rdata    = '0;
      d_rdata     = '0;
      if_err      = 1'b0;
      d_err       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (if_req || d_req) begin
               // Fetch takes the bus when it is alone, or when it has already
               // watched STARVE_MAX data grants go by.
               fetch_wins = if_req && (!d_req || starved);
               tmo_d      = '0;
               state_d    = ST_BUSY;
               if (fetch_wins) begin
                  owner_d   = OWN_IF;
                  m_we_d    = 1'b0;
                  m_addr_d  = if_addr;
                  m_wdata_d = '0;
                  m_be_d    = '1;
                  starve_d  = '0;
               end else begin
                  owner_d   = OWN_D;
                  m_we_d    = d_we;
                  m_addr_d  = d_addr;
                  m_wdata_d = d_wdata;
                  m_be_d    = d_be;
                  // Only a data grant that made fetch wait counts toward
                  // starvation; an uncontested one resets the run.
                  if (!if_req) begin
                     starve_d = '0;
                  end else if (!starved) begin
                     starve_d = starve_q + SC_W'(1);
                  end
               end
            end
         end

         ST_BUSY: begin
            m_req = 1'b1;
            if (m_ack) begin
               // A store has no read data; return zero rather than whatever
               // the memory drives on its read bus.
               rsp_rdata_d = m_we_q ? '0 : m_rdata;
               rsp_err_d   = 1'b0;
               state_d     = ST_RESP;
            end else if (tmo_q == TC_W'(TIMEOUT - 1)) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               state_d     = ST_RESP;
            end else begin
               tmo_d = tmo_q + TC_W'(1);
            end
         end

         ST_RESP: begin
            // Requests are not looked at here: the owner still holds its req
            // during the ack cycle and must not be granted a second time.
            if (owner_q == OWN_IF) begin
               if_ack   = 1'b1;
               if_rdata = rsp_rdata_q;
               if_err   = rsp_err_q;
            end else begin
               d_ack    = 1'b1;
               d_rdata  = rsp_rdata_q;
               d_err    = rsp_err_q;
            end
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign m_we     = m_we_q;
   assign m_addr   = m_addr_q;
   assign m_wdata  = m_wdata_q;
   assign m_be     = m_be_q;

   assign if_stall = if_req & ~if_ack;
   assign d_stall  = d_req  & ~d_ack;

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: non-blocking assignments here so every flop samples the values
   // computed before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_IF;
         m_we_q      <= 1'b0;
         m_addr_q    <= '0;
         m_wdata_q   <= '0;
         m_be_q      <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         starve_q    <= '0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         m_we_q      <= m_we_d;
         m_addr_q    <= m_addr_d;
         m_wdata_q   <= m_wdata_d;
         m_be_q      <= m_be_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         starve_q    <= starve_d;
         tmo_q       <= tmo_d;
      end
   end

endmodule
